mem_stall_ctrl: RTL and testbench

- Sequences each data-memory access of the 5-stage pipeline against a variable-latency data memory using a req/ack handshake.
- Holds the front of the pipeline (PC, IF/ID, ID/EX, EX/MEM) frozen while an access is outstanding.
- Forces bubbles into MEM/WB while stalled, then presents the captured read data to MEM/WB for exactly one cycle.
- Sits between the EX/MEM register outputs, the data memory and the MEM/WB register inputs.

---
 rtl/mem_stall_ctrl_pkg.sv | 19 +
 rtl/mem_stall_ctrl_if.sv | 42 ++++
 rtl/mem_stall_ctrl_sat_counter.sv | 19 +
 rtl/mem_stall_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_stall_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the data-memory stall controller: FSM states and default sizes.
package mem_stall_ctrl_pkg;

   localparam int unsigned XLEN_DEF           = 64;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
   localparam int unsigned CNT_W_DEF          = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // A real load or store is sitting in EX/MEM.
   function automatic logic is_mem_access(input logic valid, input logic rd, input logic wr);
      return valid & (rd | wr);
   endfunction

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Pipeline-side and memory-side signals of the stall controller, bundled for port hookup.
interface mem_stall_ctrl_if
   import mem_stall_ctrl_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic              EXM_valid;
   logic              EXM_MemRead;
   logic              EXM_MemWrite;
   logic [XLEN-1:0]   EXM_ALUResult;
   logic [XLEN-1:0]   EXM_WriteData;

   logic              dmem_req;
   logic              dmem_we;
   logic [XLEN-1:0]   dmem_addr;
   logic [XLEN-1:0]   dmem_wdata;
   logic              dmem_ack;
   logic [XLEN-1:0]   dmem_rdata;

   logic              stall;
   logic              mwb_bubble;
   logic [XLEN-1:0]   ReadData;
   logic              timeout_err;
   logic [CNT_W-1:0]  stall_cycles;

   // Controller view.
   modport slave (
      input  EXM_valid, EXM_MemRead, EXM_MemWrite, EXM_ALUResult, EXM_WriteData,
      input  dmem_ack, dmem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output stall, mwb_bubble, ReadData, timeout_err, stall_cycles
   );

   // Pipeline + memory view.
   modport master (
      output EXM_valid, EXM_MemRead, EXM_MemWrite, EXM_ALUResult, EXM_WriteData,
      output dmem_ack, dmem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  stall, mwb_bubble, ReadData, timeout_err, stall_cycles
   );
endinterface

// File: rtl/mem_stall_ctrl_sat_counter.sv
// Saturating up-counter for performance statistics; sticks at all-ones.
module mem_stall_ctrl_sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Sequences EX/MEM loads/stores against a variable-latency data memory,
// freezing the front of the pipeline and bubbling MEM/WB while the access is in flight.
module mem_stall_ctrl
   import mem_stall_ctrl_pkg::*;
#(
   parameter int unsigned XLEN           = XLEN_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int unsigned CNT_W          = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   mem_stall_ctrl_if.slave  bus
);

   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t            state, state_d;
   logic              mem_access;
   logic              stall, mwb_bubble, dmem_req;

   logic              we_q, we_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              to_flag_q, to_flag_d;
   logic              terr_q, terr_d;

   // Gated by reset so stall/bubble read 0 while reset is held, even with a load in EX/MEM.
   assign mem_access = reset & is_mem_access(bus.EXM_valid, bus.EXM_MemRead, bus.EXM_MemWrite);

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         to_cnt_q  <= '0;
         to_flag_q <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         state     <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         to_cnt_q  <= to_cnt_d;
         to_flag_q <= to_flag_d;
         terr_q    <= terr_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d    = state;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      to_cnt_d   = to_cnt_q;
      to_flag_d  = to_flag_q;
      terr_d     = terr_q;
      stall      = 1'b0;
      mwb_bubble = 1'b0;
      dmem_req   = 1'b0;

      case (state)
         ST_IDLE: begin
            stall      = mem_access;
            mwb_bubble = mem_access;
            if (mem_access) begin
               we_d     = bus.EXM_MemWrite;
               addr_d   = bus.EXM_ALUResult;
               wdata_d  = bus.EXM_WriteData;
               to_cnt_d = '0;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            dmem_req   = 1'b1;
            stall      = 1'b1;
            mwb_bubble = 1'b1;
            to_cnt_d   = to_cnt_q + TO_W'(1);
            // An ack on the terminal cycle takes priority over the timeout.
            if (bus.dmem_ack) begin
               if (!we_q) begin
                  rdata_d = bus.dmem_rdata;
               end
               to_flag_d = 1'b0;
               state_d   = ST_DONE;
            end else if (to_cnt_q == TO_LAST) begin
               terr_d    = 1'b1;
               to_flag_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            mwb_bubble = to_flag_q;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   mem_stall_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (stall),
      .count (bus.stall_cycles)
   );

   assign bus.stall       = stall;
   assign bus.mwb_bubble  = mwb_bubble;
   assign bus.dmem_req    = dmem_req;
   assign bus.dmem_we     = we_q;
   assign bus.dmem_addr   = addr_q;
   assign bus.dmem_wdata  = wdata_q;
   assign bus.ReadData    = rdata_q;
   assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl with a 4-cycle access timeout.
module tb_mem_stall_ctrl;
   import mem_stall_ctrl_pkg::*;

   localparam int unsigned XL = 64;
   localparam int unsigned CW = 32;
   localparam int          TO = 4;

   typedef struct {
      logic          rd;
      logic          wr;
      logic [XL-1:0] addr;
      logic [XL-1:0] wdata;
      logic [XL-1:0] rdata;
      int            ack_n;     // 0 = memory never answers
      logic          exp_we;
      logic          exp_to;
   } vec_t;

   typedef struct {
      logic [XL-1:0] rd;
      logic          bubble;
      logic          terr;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   exp_sc = 0;
   logic [XL-1:0] model_rdata = '0;
   logic          model_terr  = 1'b0;
   exp_t          sb[$];
   vec_t          vecs[7];

   mem_stall_ctrl_if #(.XLEN(XL), .CNT_W(CW)) bus ();

   mem_stall_ctrl #(.XLEN(XL), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // One full access; leaves the DUT at the negedge of its DONE cycle.
   task automatic do_access(input vec_t v, input logic spurious_done);
      exp_t e;
      logic acked;
      acked = (v.ack_n >= 1) && (v.ack_n <= TO);
      if (acked && !v.exp_we) model_rdata = v.rdata;
      if (!acked) model_terr = 1'b1;
      e.rd = model_rdata; e.bubble = !acked; e.terr = model_terr;
      sb.push_back(e);

      @(posedge clk); #1;
      bus.EXM_valid = 1'b1; bus.EXM_MemRead = v.rd; bus.EXM_MemWrite = v.wr;
      bus.EXM_ALUResult = v.addr; bus.EXM_WriteData = v.wdata;
      bus.dmem_ack = 1'b0;
      @(negedge clk);
      chk("idle_stall", 64'(bus.stall), 64'd1);
      chk("idle_req", 64'(bus.dmem_req), 64'd0);
      chk("idle_bubble", 64'(bus.mwb_bubble), 64'd1);
      exp_sc++;

      for (int c = 1; c <= TO; c++) begin
         @(posedge clk); #1;
         bus.dmem_ack   = (c == v.ack_n);
         bus.dmem_rdata = (c == v.ack_n) ? v.rdata : ~v.rdata;
         @(negedge clk);
         chk("acc_req", 64'(bus.dmem_req), 64'd1);
         chk("acc_stall", 64'(bus.stall), 64'd1);
         chk("acc_bubble", 64'(bus.mwb_bubble), 64'd1);
         chk("acc_we", 64'(bus.dmem_we), 64'(v.exp_we));
         chk("acc_addr", bus.dmem_addr, v.addr);
         if (v.exp_we) chk("acc_wdata", bus.dmem_wdata, v.wdata);
         exp_sc++;
         if (c == v.ack_n) break;
      end

      @(posedge clk); #1;
      bus.dmem_ack   = spurious_done;
      bus.dmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      chk("done_stall", 64'(bus.stall), 64'd0);
      chk("done_req", 64'(bus.dmem_req), 64'd0);
      chk("done_cycles", bus.stall_cycles, 64'(exp_sc));
      if (sb.size() == 0) begin
         chk("sb_empty", 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         chk("done_rdata", bus.ReadData, e.rd);
         chk("done_bubble", 64'(bus.mwb_bubble), 64'(e.bubble));
         chk("done_terr", 64'(bus.timeout_err), 64'(e.terr));
      end
   endtask

   // Pipeline moves on with no memory op; a non-valid load must not stall.
   task automatic idle_gap();
      @(posedge clk); #1;
      bus.EXM_valid = 1'b0; bus.EXM_MemRead = 1'b1; bus.dmem_ack = 1'b0;
      @(negedge clk);
      chk("gap_stall", 64'(bus.stall), 64'd0);
      chk("gap_req", 64'(bus.dmem_req), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, 64'(bus.dmem_req), 64'd0);
      chk({tag, "_we"}, 64'(bus.dmem_we), 64'd0);
      chk({tag, "_stall"}, 64'(bus.stall), 64'd0);
      chk({tag, "_bubble"}, 64'(bus.mwb_bubble), 64'd0);
      chk({tag, "_terr"}, 64'(bus.timeout_err), 64'd0);
      chk({tag, "_addr"}, bus.dmem_addr, 64'd0);
      chk({tag, "_wdata"}, bus.dmem_wdata, 64'd0);
      chk({tag, "_rdata"}, bus.ReadData, 64'd0);
      chk({tag, "_cycles"}, bus.stall_cycles, 64'd0);
   endtask

   initial begin
      vec_t b0, b1, r0;
      logic [CW-1:0] base;

      //         rd    wr    addr       wdata      rdata                   ack  we    to
      vecs[0] = '{1'b1, 1'b0, 64'h100, 64'h0,    64'hDEAD_BEEF,           1,  1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 64'h200, 64'h55,   64'h1234,                4,  1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 64'h300, 64'h0,    64'hCAFE_F00D,           2,  1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 64'h400, 64'h0,    64'h0123_4567_89AB_CDEF, 4,  1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 64'h500, 64'h0,    64'h9999,                0,  1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 64'h600, 64'h0,    64'hA5A5,                3,  1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 64'h700, 64'h77,   64'h4444,                1,  1'b1, 1'b0};

      bus.EXM_valid = 1'b1; bus.EXM_MemRead = 1'b1; bus.EXM_MemWrite = 1'b0;
      bus.EXM_ALUResult = 64'h123; bus.EXM_WriteData = '0;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("rst");
      bus.EXM_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         do_access(vecs[i], 1'b0);
         idle_gap();
      end

      // Back-to-back loads with a stray ack during the first DONE.
      base = bus.stall_cycles;
      b0 = '{1'b1, 1'b0, 64'h800, 64'h0, 64'h1111_2222, 1, 1'b0, 1'b0};
      b1 = '{1'b1, 1'b0, 64'h808, 64'h0, 64'h3333_4444, 1, 1'b0, 1'b0};
      do_access(b0, 1'b1);
      do_access(b1, 1'b0);
      chk("b2b_cycles", 64'(bus.stall_cycles - base), 64'd4);
      idle_gap();

      // Reset pulled in the middle of an access.
      @(posedge clk); #1;
      bus.EXM_valid = 1'b1; bus.EXM_MemRead = 1'b1; bus.EXM_MemWrite = 1'b0;
      bus.EXM_ALUResult = 64'h900;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_req_pre", 64'(bus.dmem_req), 64'd1);
      reset = 1'b0;
      #1;
      chk_all_zero("mid");
      bus.EXM_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_rdata = '0; model_terr = 1'b0; exp_sc = 0;
      r0 = '{1'b1, 1'b0, 64'hA00, 64'h0, 64'h5A5A_5A5A, 2, 1'b0, 1'b0};
      do_access(r0, 1'b0);
      idle_gap();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
